// File: rtl/dror_validator_stream.sv
// DROR/ROR point validator: streams LANES candidates per beat, counts neighbours of one
// query point within a fixed or range-dependent radius, and reports an inlier/outlier verdict.
module dror_validator_stream #(
  parameter int N            = 16,
  parameter int LANES        = 8,
  parameter int CNT_W        = 16,
  parameter int DIST_LATENCY = 2,
  parameter int ANG_SHIFT    = 3,
  parameter int MIN_RADIUS   = 1
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_start,
  input  logic [N-1:0]       i_point_x,
  input  logic [N-1:0]       i_point_y,
  input  logic [N-1:0]       i_point_z,
  input  logic [2*N-1:0]     i_cloud_size,
  input  logic [CNT_W-1:0]   i_threshold,
  input  logic               i_mode,
  input  logic [N-1:0]       i_fixed_radius,
  input  logic               i_cp_valid,
  output logic               o_cp_ready,
  input  logic [N*LANES-1:0] i_cp_x,
  input  logic [N*LANES-1:0] i_cp_y,
  input  logic [N*LANES-1:0] i_cp_z,
  input  logic [LANES-1:0]   i_cp_mask,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_inlier,
  output logic               o_outlier,
  output logic [CNT_W-1:0]   o_neighbors
);
  localparam int DW = N + 2;
  localparam int AW = 2 * N;
  localparam int PW = $clog2(LANES + 1);
  localparam int RW = $clog2(DIST_LATENCY + 1) + 1;
  localparam int SW = N + 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RADIUS = 3'd1,
    S_STREAM = 3'd2,
    S_DRAIN  = 3'd3,
    S_DONE   = 3'd4,
    S_HOLD   = 3'd5
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [N-1:0]     r_px, r_py, r_pz, r_fixed, r_radius;
  logic [AW-1:0]    r_size, r_accepted;
  logic [CNT_W-1:0] r_thr, r_count, r_neighbors;
  logic             r_mode, r_busy, r_done, r_inlier, r_outlier;
  logic [RW-1:0]    r_rcnt;
  logic [LANES-1:0] r_live_pipe [DIST_LATENCY];
  logic [DW-1:0]    r_dist_pipe [DIST_LATENCY][LANES];
  logic [SW-1:0]    r_sens_pipe [DIST_LATENCY];

  logic             w_start_ok, w_fire, w_early, w_pipe_empty, w_radius_last;
  logic [LANES-1:0] w_live, w_hits;
  logic [DW-1:0]    w_lane_dist [LANES];
  logic [PW-1:0]    w_live_cnt, w_hit_cnt;
  logic [AW-1:0]    w_acc_next;
  logic [CNT_W:0]   w_count_sum;
  logic [CNT_W-1:0] w_count_next;
  logic [SW-1:0]    w_sens_shift;
  logic [N-1:0]     w_radius_calc;

  function automatic logic [N-1:0] absdiff(input logic [N-1:0] a, input logic [N-1:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

  // Distance metric is L1 (Manhattan), kept at full N+2 width so it never saturates.
  function automatic logic [DW-1:0] l1_dist(input logic [N-1:0] ax, input logic [N-1:0] ay,
                                            input logic [N-1:0] az, input logic [N-1:0] bx,
                                            input logic [N-1:0] by, input logic [N-1:0] bz);
    return DW'(absdiff(ax, bx)) + DW'(absdiff(ay, by)) + DW'(absdiff(az, bz));
  endfunction

  assign w_start_ok    = i_start && ((r_state == S_IDLE) || (r_state == S_HOLD));
  assign w_early       = ((r_state == S_STREAM) || (r_state == S_DRAIN)) && (r_count >= r_thr);
  assign o_cp_ready    = (r_state == S_STREAM) && !w_early;
  assign w_fire        = i_cp_valid && o_cp_ready;
  assign w_radius_last = (r_rcnt == RW'(DIST_LATENCY));
  assign w_acc_next    = r_accepted + AW'(w_live_cnt);
  assign w_sens_shift  = r_sens_pipe[DIST_LATENCY-1] >> ANG_SHIFT;

  // Lane liveness compares in 2N+1 bits so accepted+k cannot wrap past cloud_size.
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    assign w_lane_dist[k] = l1_dist(r_px, r_py, r_pz,
                                    i_cp_x[k*N +: N], i_cp_y[k*N +: N], i_cp_z[k*N +: N]);
    assign w_live[k] = i_cp_mask[k] &&
                       (({1'b0, r_accepted} + (AW+1)'(k)) < {1'b0, r_size});
    assign w_hits[k] = r_live_pipe[DIST_LATENCY-1][k] &&
                       (r_dist_pipe[DIST_LATENCY-1][k] <= DW'(r_radius));
  end

  always_comb begin
    w_live_cnt   = '0;
    w_hit_cnt    = '0;
    w_pipe_empty = 1'b1;
    for (int k = 0; k < LANES; k++) begin
      w_live_cnt = w_live_cnt + PW'(w_live[k]);
      w_hit_cnt  = w_hit_cnt + PW'(w_hits[k]);
    end
    for (int i = 0; i < DIST_LATENCY; i++) begin
      if (r_live_pipe[i] != '0) begin
        w_pipe_empty = 1'b0;
      end else begin
        w_pipe_empty = w_pipe_empty;
      end
    end
  end

  always_comb begin
    w_count_sum = {1'b0, r_count} + (CNT_W+1)'(w_hit_cnt);
    if (w_count_sum[CNT_W]) begin
      w_count_next = '1;
    end else begin
      w_count_next = w_count_sum[CNT_W-1:0];
    end
  end

  always_comb begin
    if (!r_mode) begin
      w_radius_calc = r_fixed;
    end else if (w_sens_shift < SW'(MIN_RADIUS)) begin
      w_radius_calc = N'(MIN_RADIUS);
    end else if (w_sens_shift[SW-1]) begin
      w_radius_calc = '1;
    end else begin
      w_radius_calc = w_sens_shift[N-1:0];
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE, S_HOLD: begin
        if (w_start_ok) w_state_next = S_RADIUS;
        else            w_state_next = r_state;
      end
      S_RADIUS: begin
        if (!w_radius_last)                          w_state_next = S_RADIUS;
        else if ((r_thr == '0) || (r_size == '0))    w_state_next = S_DONE;
        else                                         w_state_next = S_STREAM;
      end
      S_STREAM: begin
        if (w_early)                                 w_state_next = S_DONE;
        else if (w_fire && (w_acc_next >= r_size))   w_state_next = S_DRAIN;
        else                                         w_state_next = S_STREAM;
      end
      // DRAIN ends once no live lanes remain in flight; the counter is then final.
      S_DRAIN: begin
        if (w_early || w_pipe_empty) w_state_next = S_DONE;
        else                         w_state_next = S_DRAIN;
      end
      S_DONE:  w_state_next = S_HOLD;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      for (int i = 0; i < DIST_LATENCY; i++) begin
        r_live_pipe[i] <= '0;
        r_sens_pipe[i] <= '0;
        for (int k = 0; k < LANES; k++) r_dist_pipe[i][k] <= '0;
      end
    end else begin
      r_live_pipe[0] <= w_fire ? w_live : '0;
      r_sens_pipe[0] <= SW'(r_px) + SW'(r_py);
      for (int k = 0; k < LANES; k++) r_dist_pipe[0][k] <= w_lane_dist[k];
      for (int i = 1; i < DIST_LATENCY; i++) begin
        r_live_pipe[i] <= r_live_pipe[i-1];
        r_sens_pipe[i] <= r_sens_pipe[i-1];
        for (int k = 0; k < LANES; k++) r_dist_pipe[i][k] <= r_dist_pipe[i-1][k];
      end
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state     <= S_IDLE;
      r_px        <= '0;
      r_py        <= '0;
      r_pz        <= '0;
      r_fixed     <= '0;
      r_radius    <= '0;
      r_size      <= '0;
      r_accepted  <= '0;
      r_thr       <= '0;
      r_count     <= '0;
      r_neighbors <= '0;
      r_mode      <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_inlier    <= 1'b0;
      r_outlier   <= 1'b0;
      r_rcnt      <= '0;
    end else begin
      r_state <= w_state_next;
      r_busy  <= (w_state_next == S_RADIUS) || (w_state_next == S_STREAM) ||
                 (w_state_next == S_DRAIN)  || (w_state_next == S_DONE);
      r_done  <= (w_state_next == S_DONE);
      if (w_start_ok) begin
        r_px        <= i_point_x;
        r_py        <= i_point_y;
        r_pz        <= i_point_z;
        r_size      <= i_cloud_size;
        r_thr       <= i_threshold;
        r_mode      <= i_mode;
        r_fixed     <= i_fixed_radius;
        r_count     <= '0;
        r_accepted  <= '0;
        r_rcnt      <= '0;
        r_neighbors <= '0;
        r_inlier    <= 1'b0;
        r_outlier   <= 1'b0;
      end else begin
        if (r_state == S_RADIUS) begin
          r_rcnt   <= r_rcnt + RW'(1);
          r_radius <= w_radius_calc;
        end
        if (w_fire) r_accepted <= w_acc_next;
        // Freezing the counter once the threshold is met discards beats still in flight.
        if (((r_state == S_STREAM) || (r_state == S_DRAIN)) && !w_early) begin
          r_count <= w_count_next;
        end
        if (w_state_next == S_DONE) begin
          r_inlier    <= (r_count >= r_thr);
          r_outlier   <= !(r_count >= r_thr);
          r_neighbors <= r_count;
        end
      end
    end
  end

  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_inlier    = r_inlier;
  assign o_outlier   = r_outlier;
  assign o_neighbors = r_neighbors;
endmodule

// File: tb/tb_dror_validator_stream.sv
// Bench for dror_validator_stream: directed vector table plus randomized queries
// checked against a beat-level reference model of neighbour counting.
module tb_dror_validator_stream;
  localparam int N     = 16;
  localparam int LANES = 4;
  localparam int CNT_W = 16;
  localparam int DL    = 2;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                start = 1'b0;
  logic [N-1:0]        px = '0, py = '0, pz = '0, fixed_r = '0;
  logic [2*N-1:0]      csize = '0;
  logic [CNT_W-1:0]    thr = '0;
  logic                mode = 1'b0;
  logic                cp_valid = 1'b0;
  logic                cp_ready;
  logic [N*LANES-1:0]  cp_x = '0, cp_y = '0, cp_z = '0;
  logic [LANES-1:0]    cp_mask = '0;
  logic                busy, done, inlier, outlier;
  logic [CNT_W-1:0]    nbrs;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  dror_validator_stream #(
    .N(N), .LANES(LANES), .CNT_W(CNT_W), .DIST_LATENCY(DL), .ANG_SHIFT(3), .MIN_RADIUS(1)
  ) dut (
    .i_clock(clk), .i_reset(rst), .i_start(start),
    .i_point_x(px), .i_point_y(py), .i_point_z(pz),
    .i_cloud_size(csize), .i_threshold(thr), .i_mode(mode), .i_fixed_radius(fixed_r),
    .i_cp_valid(cp_valid), .o_cp_ready(cp_ready),
    .i_cp_x(cp_x), .i_cp_y(cp_y), .i_cp_z(cp_z), .i_cp_mask(cp_mask),
    .o_busy(busy), .o_done(done), .o_inlier(inlier), .o_outlier(outlier),
    .o_neighbors(nbrs)
  );

  typedef struct {
    logic [LANES-1:0][N-1:0] x;
    logic [LANES-1:0][N-1:0] y;
    logic [LANES-1:0][N-1:0] z;
    logic [LANES-1:0]        mask;
    int                      t;
  } beat_t;

  typedef struct {
    bit          mode;
    int          px;
    int          fixed;
    int          size;
    int          thr;
    logic [63:0] hitpat;
    int          hoff;
    int          exp_in;
    int          exp_nb;
    int          exp_beats;
  } vec_t;

  beat_t beats[$];
  vec_t  vt[9];
  int    errors = 0;
  int    checks = 0;
  int    q_mode, q_px, q_py, q_pz, q_fixed, q_size, q_thr, q_hoff;
  logic [63:0] q_hit;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int l1(input int ax, input int ay, input int az,
                            input int bx, input int by, input int bz);
    int dx = (ax > bx) ? ax - bx : bx - ax;
    int dy = (ay > by) ? ay - by : by - ay;
    int dz = (az > bz) ? az - bz : bz - az;
    return dx + dy + dz;
  endfunction

  task automatic gen_beat(input bit rnd, input int idx, output beat_t b);
    int slot, xv, yv, zv;
    bit hit;
    for (int k = 0; k < LANES; k++) begin
      if (rnd) begin
        xv = q_px + int'($urandom_range(0, 50)) - 25;
        yv = q_py + int'($urandom_range(0, 50)) - 25;
        zv = q_pz + int'($urandom_range(0, 50)) - 25;
      end else begin
        slot = idx * LANES + k;
        hit  = (slot < 64) ? q_hit[slot] : 1'b0;
        xv   = hit ? q_px - q_hoff : q_px + 50;
        yv   = q_py;
        zv   = q_pz;
      end
      b.x[k] = 16'(xv);
      b.y[k] = 16'(yv);
      b.z[k] = 16'(zv);
    end
    b.mask = rnd ? 4'($urandom_range(0, 15)) : 4'hF;
    b.t    = 0;
  endtask

  // Reference: walk accepted beats in order; count stops with the beat that meets the threshold.
  task automatic model(output int nb, output int xi);
    int radius, acc, lc, h;
    bit live;
    radius = q_mode ? (((q_px + q_py) >> 3) < 1 ? 1 : ((q_px + q_py) >> 3)) : q_fixed;
    acc = 0; nb = 0; xi = -1;
    foreach (beats[i]) begin
      lc = 0; h = 0;
      for (int k = 0; k < LANES; k++) begin
        live = beats[i].mask[k] && (acc + k < q_size);
        if (live) begin
          lc++;
          if (l1(int'(beats[i].x[k]), int'(beats[i].y[k]), int'(beats[i].z[k]),
                 q_px, q_py, q_pz) <= radius) h++;
        end
      end
      acc += lc;
      if (xi < 0) begin
        nb += h;
        if (nb >= q_thr) xi = i;
      end
    end
  endtask

  task automatic apply_cfg();
    mode = q_mode[0]; px = 16'(q_px); py = 16'(q_py); pz = 16'(q_pz);
    fixed_r = 16'(q_fixed); csize = 32'(q_size); thr = 16'(q_thr);
  endtask

  task automatic run_query(input bit rnd, input bit stray, input int exp_in, input int exp_nb,
                           input int exp_beats, input string tag);
    int s, first_ready, done_cyc, m_nb, m_xi, e_in, e_nb, exp_done;
    bit have, rdy;
    beat_t cur;
    first_ready = -1; done_cyc = -1; have = 1'b0;
    beats.delete();
    apply_cfg();
    start = 1'b1; s = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    check({tag, "_busy_start"}, busy, 1);
    for (int n = 0; n < 400; n++) begin
      if (done) begin done_cyc = cyc; break; end
      if (cp_ready && first_ready < 0) first_ready = cyc;
      if (stray && first_ready >= 0 && cyc == first_ready + 1) begin
        start = 1'b1; thr = '0; csize = '0;
      end else begin
        start = 1'b0;
      end
      if (!have) begin gen_beat(rnd, beats.size(), cur); have = 1'b1; end
      cp_x = cur.x; cp_y = cur.y; cp_z = cur.z; cp_mask = cur.mask;
      cp_valid = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      rdy = cp_ready; cur.t = cyc;
      @(posedge clk);
      if (cp_valid && rdy) begin beats.push_back(cur); have = 1'b0; end
      #1;
    end
    start = 1'b0; cp_valid = 1'b0;
    if (done_cyc < 0) begin
      checks++; errors++;
      $display("FAIL %s_timeout: got no done expected done within 400 cycles", tag);
      return;
    end
    model(m_nb, m_xi);
    e_in = rnd ? int'(m_nb >= q_thr) : exp_in;
    e_nb = rnd ? m_nb : exp_nb;
    if (beats.size() == 0) exp_done = s + DL + 2;
    else if (m_xi >= 0)    exp_done = beats[m_xi].t + DL + 2;
    else                   exp_done = beats[beats.size()-1].t + DL + 2;
    check({tag, "_inlier"}, inlier, e_in);
    check({tag, "_outlier"}, outlier, 1 - e_in);
    check({tag, "_neighbors"}, nbrs, e_nb);
    check({tag, "_busy_at_done"}, busy, 1);
    check({tag, "_ready_at_done"}, cp_ready, 0);
    check({tag, "_done_cycle"}, done_cyc, exp_done);
    if (!rnd) check({tag, "_beats"}, beats.size(), exp_beats);
    if (q_thr != 0 && q_size != 0) check({tag, "_first_ready"}, first_ready, s + DL + 2);
    @(posedge clk); #1;
    check({tag, "_done_pulse"}, done, 0);
    check({tag, "_busy_after"}, busy, 0);
    check({tag, "_inlier_held"}, inlier, e_in);
    check({tag, "_nb_held"}, nbrs, e_nb);
  endtask

  initial begin
    vt[0] = '{1'b1, 80, 0,  8, 3, 64'h13, 5, 1, 3, 2};
    vt[1] = '{1'b1, 80, 0,  8, 4, 64'h13, 5, 0, 3, 2};
    vt[2] = '{1'b1, 80, 0,  6, 8, 64'hC3, 5, 0, 2, 2};
    vt[3] = '{1'b1, 80, 0, 40, 4, 64'hFFFF_FFFF_FFFF_FFFF, 5, 1, 4, 3};
    vt[4] = '{1'b0, 80, 0,  1, 1, 64'h1, 0, 1, 1, 1};
    vt[5] = '{1'b1, 80, 0,  8, 0, 64'hFF, 5, 1, 0, 0};
    vt[6] = '{1'b1, 80, 0,  0, 2, 64'hFF, 5, 0, 0, 0};
    vt[7] = '{1'b0, 80, 20, 4, 4, 64'hF, 20, 1, 4, 1};
    vt[8] = '{1'b0, 80, 20, 4, 1, 64'hF, 21, 0, 0, 1};

    repeat (2) @(posedge clk);
    #1;
    check("reset_ready", cp_ready, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_inlier", inlier, 0);
    check("reset_outlier", outlier, 0);
    check("reset_neighbors", nbrs, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 9; i++) begin
      q_mode = int'(vt[i].mode); q_px = vt[i].px; q_py = 0; q_pz = 0;
      q_fixed = vt[i].fixed; q_size = vt[i].size; q_thr = vt[i].thr;
      q_hit = vt[i].hitpat; q_hoff = vt[i].hoff;
      run_query(1'b0, (i == 2), vt[i].exp_in, vt[i].exp_nb, vt[i].exp_beats,
                $sformatf("vec%0d", i));
    end

    // Reset asserted asynchronously while a query is streaming.
    begin
      beat_t b;
      q_mode = 0; q_px = 80; q_py = 0; q_pz = 0; q_fixed = 0;
      q_size = 40; q_thr = 100; q_hit = '1; q_hoff = 0;
      apply_cfg();
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int n = 0; n < 10 && !cp_ready; n++) begin @(posedge clk); #1; end
      gen_beat(1'b0, 0, b);
      cp_x = b.x; cp_y = b.y; cp_z = b.z; cp_mask = b.mask; cp_valid = 1'b1;
      repeat (2) begin @(posedge clk); #1; end
      check("midrst_ready_before", cp_ready, 1);
      check("midrst_busy_before", busy, 1);
      rst = 1'b1;
      #1;
      check("midrst_ready", cp_ready, 0);
      check("midrst_busy", busy, 0);
      check("midrst_done", done, 0);
      check("midrst_inlier", inlier, 0);
      check("midrst_outlier", outlier, 0);
      check("midrst_nb", nbrs, 0);
      @(posedge clk); #1;
      rst = 1'b0; cp_valid = 1'b0;
      @(posedge clk); #1;
      check("postrst_ready", cp_ready, 0);
      check("postrst_busy", busy, 0);
      q_mode = 1; q_px = 80; q_size = 8; q_thr = 3; q_hit = 64'h13; q_hoff = 5;
      run_query(1'b0, 1'b0, 1, 3, 2, "fresh");
    end

    for (int r = 0; r < 40; r++) begin
      q_mode  = int'($urandom_range(0, 1));
      q_px    = int'($urandom_range(30, 200));
      q_py    = int'($urandom_range(30, 200));
      q_pz    = int'($urandom_range(30, 100));
      q_fixed = int'($urandom_range(0, 40));
      q_size  = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 30));
      q_thr   = int'($urandom_range(0, 12));
      run_query(1'b1, 1'b0, 0, 0, 0, $sformatf("rnd%0d", r));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
